// File: rtl/irq_gateway_pkg.sv
// irq_gateway_pkg
// Shared types and helpers for the interrupt gateway.
//   trig_mode_e            : per-source trigger mode (level / rising edge)
//   DefaultMaxPendingEdges : default depth of the per-source edge counter
//   id_width()             : width of claim/complete IDs for a source count
// Optional build macro used by the gateway files: IRQ_GATEWAY_SYNC_EN.
package irq_gateway_pkg;

  typedef enum logic {
    TrigLevel = 1'b0,
    TrigEdge  = 1'b1
  } trig_mode_e;

  localparam int unsigned DefaultMaxPendingEdges = 4;

  // Source 0 is reserved but still occupies an ID, so IDs span 0..num_irqs-1.
  function automatic int unsigned id_width(input int unsigned num_irqs);
    return (num_irqs < 2) ? 1 : $clog2(num_irqs);
  endfunction

endpackage

// File: rtl/irq_gateway_src.sv
// irq_gateway_src
// Per-source gateway slice: input sampling, rising-edge detection, saturating
// edge counter, claim/complete in-flight tracking and sticky overflow flag.
// Build macro IRQ_GATEWAY_SYNC_EN inserts a 2-flop synchroniser ahead of the
// sampling register (irq -> pending latency 3 cycles instead of 1).
// Ports:
//   clk, rst      : core clock, synchronous active-high reset
//   irq           : raw interrupt line
//   mode          : TrigLevel / TrigEdge, quasi-static
//   claim_sel     : claim strobe already decoded for this source
//   complete_sel  : complete strobe already decoded for this source
//   pending       : request towards the PLIC core
//   overflow      : sticky edge-counter overflow
module irq_gateway_src
  import irq_gateway_pkg::*;
#(
  parameter int unsigned MaxPendingEdges = DefaultMaxPendingEdges
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq,
  input  trig_mode_e mode,
  input  logic       claim_sel,
  input  logic       complete_sel,
  output logic       pending,
  output logic       overflow
);

  localparam int unsigned      CntW   = $clog2(MaxPendingEdges + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxPendingEdges);

  logic            irq_in;
  logic            irq_q;
  logic            prev_q;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_d;
  logic            inflight;
  logic            inflight_d;
  logic            overflow_d;
  logic            is_edge;
  logic            rise;
  logic            claim_ok;
  logic            complete_ok;

`ifdef IRQ_GATEWAY_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  // Synchroniser stages for lines coming from a foreign clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= irq;
      sync_p1 <= sync_p0;
    end
  end

  assign irq_in = sync_p1;
`else
  assign irq_in = irq;
`endif

  assign is_edge = (mode == TrigEdge);
  // prev_q clears on reset, so a line already high at release counts once.
  assign rise    = irq_q & ~prev_q;

  // Request is derived from registered state only.
  assign pending = is_edge ? ((cnt != '0) & ~inflight) : (irq_q & ~inflight);

  // A claim needs a live request; a complete needs an outstanding claim.
  // The two are mutually exclusive for one source in one cycle.
  assign claim_ok    = claim_sel & pending;
  assign complete_ok = complete_sel & inflight;

  always_comb begin
    cnt_d      = cnt;
    inflight_d = inflight;
    overflow_d = overflow;

    if (claim_ok) begin
      inflight_d = 1'b1;
    end else if (complete_ok) begin
      inflight_d = 1'b0;
    end

    if (!is_edge) begin
      cnt_d = '0;
    end else if (rise && claim_ok) begin
      cnt_d = cnt;
    end else if (rise) begin
      if (cnt == CntMax) begin
        overflow_d = 1'b1;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end else if (claim_ok) begin
      cnt_d = cnt - 1'b1;
    end
  end

  // Sampling register and per-source state
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q    <= 1'b0;
      prev_q   <= 1'b0;
      cnt      <= '0;
      inflight <= 1'b0;
      overflow <= 1'b0;
    end else begin
      irq_q    <= irq_in;
      prev_q   <= irq_q;
      cnt      <= cnt_d;
      inflight <= inflight_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: rtl/irq_gateway.sv
// irq_gateway
// Interrupt gateway between raw device IRQ lines and the PLIC core. Holds one
// irq_gateway_src slice per source 1..NumIrqs-1; this level only decodes the
// claim/complete IDs into per-source strobes. Source 0 is reserved.
// Build macro IRQ_GATEWAY_SYNC_EN adds a 2-flop synchroniser per source.
// Ports:
//   clk_i, rst_i       : core clock, synchronous active-high reset
//   irq_i              : raw interrupt lines (bit 0 ignored)
//   edge_trigger_i     : per-source mode, 1 = rising edge, 0 = level
//   pending_o          : requests to the PLIC core (bit 0 always 0)
//   claim_i/_id_i      : one-cycle claim strobe and claimed source
//   complete_i/_id_i   : one-cycle completion strobe and completed source
//   overflow_o         : sticky edge-counter overflow flags
module irq_gateway
  import irq_gateway_pkg::*;
#(
  parameter int unsigned NumIrqs         = 32,
  parameter int unsigned MaxPendingEdges = DefaultMaxPendingEdges,
  parameter int unsigned IdWidth         = id_width(NumIrqs)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumIrqs-1:0] irq_i,
  input  logic [NumIrqs-1:0] edge_trigger_i,
  output logic [NumIrqs-1:0] pending_o,
  input  logic               claim_i,
  input  logic [IdWidth-1:0] claim_id_i,
  input  logic               complete_i,
  input  logic [IdWidth-1:0] complete_id_i,
  output logic [NumIrqs-1:0] overflow_o
);

  logic [NumIrqs-1:1] claim_sel;
  logic [NumIrqs-1:1] complete_sel;
  logic               unused_src0;

  // Source 0 inputs are deliberately not used.
  assign unused_src0   = irq_i[0] ^ edge_trigger_i[0];
  assign pending_o[0]  = 1'b0;
  assign overflow_o[0] = 1'b0;

  // Only IDs 1..NumIrqs-1 have a matching slice, so ID 0 and out-of-range
  // IDs decode to no strobe at all and are dropped without side effects.
  for (genvar i = 1; i < NumIrqs; i++) begin : g_src
    assign claim_sel[i]    = claim_i    && (claim_id_i    == IdWidth'(i));
    assign complete_sel[i] = complete_i && (complete_id_i == IdWidth'(i));

    irq_gateway_src #(
      .MaxPendingEdges(MaxPendingEdges)
    ) u_src (
      .clk         (clk_i),
      .rst         (rst_i),
      .irq         (irq_i[i]),
      .mode        (trig_mode_e'(edge_trigger_i[i])),
      .claim_sel   (claim_sel[i]),
      .complete_sel(complete_sel[i]),
      .pending     (pending_o[i]),
      .overflow    (overflow_o[i])
    );
  end

endmodule
